// File: rtl/game_ui_pkg.sv
// Shared types and constants for the health-bar UI script sequencer:
// FSM encoding, ROM word field layout, HOLD marker and reset values.
package game_ui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_APPLY = 3'd4,
    ST_DONE  = 3'd5
  } ui_seq_state_t;

  localparam int UI_RST_BIT  = 63;
  localparam int UI_X_LSB    = 53;
  localparam int UI_Y_LSB    = 43;
  localparam int UI_W_LSB    = 33;
  localparam int UI_H_LSB    = 23;
  localparam int UI_GEOM_W   = 10;
  localparam int UI_SENS_LSB = 16;
  localparam int UI_SENS_W   = 7;
  localparam int UI_WAIT_LSB = 0;
  localparam int UI_WAIT_W   = 16;

  localparam logic [UI_WAIT_W-1:0] UI_HOLD_MARKER = 16'hFFFF;
  localparam logic [UI_SENS_W-1:0] UI_SENS_RESET  = 7'd127;

  typedef struct packed {
    logic                 rst;
    logic [UI_GEOM_W-1:0] x;
    logic [UI_GEOM_W-1:0] y;
    logic [UI_GEOM_W-1:0] w;
    logic [UI_GEOM_W-1:0] h;
    logic [UI_SENS_W-1:0] sens;
    logic [UI_WAIT_W-1:0] wait_time;
  } ui_entry_t;

  function automatic logic is_hold(input logic [UI_WAIT_W-1:0] wait_time);
    return wait_time == UI_HOLD_MARKER;
  endfunction

endpackage

// File: rtl/game_ui_sequencer_if.sv
// Bus bundle between the UI script sequencer, the UI ROM and the health-bar
// renderer. master = sequencer side, slave = ROM/game/renderer side.
interface game_ui_sequencer_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int ENTRY_WIDTH   = 64
);
  import game_ui_pkg::*;

  // Handshake: no valid/ready; the ROM is fixed-latency with no backpressure,
  // so rom_data always reflects the rom_addr presented one cycle earlier.
  logic                     start;
  logic                     abort;
  logic [MAXIMUM_TIMES-1:0] current_time;
  logic [ADDR_WIDTH-1:0]    rom_addr;
  logic [ENTRY_WIDTH-1:0]   rom_data;
  logic [9:0]               health_bar_pos_x;
  logic [9:0]               health_bar_pos_y;
  logic [9:0]               health_bar_w;
  logic [9:0]               health_bar_h;
  logic [6:0]               health_bar_sensitivity;
  logic                     health_reset;
  logic                     entry_applied;
  logic [MAXIMUM_TIMES-1:0] next_ui_time;
  logic                     running;
  logic                     done;
  ui_seq_state_t            dbg_state;

  modport master (
    input  start, abort, current_time, rom_data,
    output rom_addr, health_bar_pos_x, health_bar_pos_y, health_bar_w,
           health_bar_h, health_bar_sensitivity, health_reset, entry_applied,
           next_ui_time, running, done, dbg_state
  );

  modport slave (
    output start, abort, current_time, rom_data,
    input  rom_addr, health_bar_pos_x, health_bar_pos_y, health_bar_w,
           health_bar_h, health_bar_sensitivity, health_reset, entry_applied,
           next_ui_time, running, done, dbg_state
  );

endinterface

// File: rtl/game_ui_entry_decode.sv
// Combinational unpack of one UI ROM word into its named fields; also used
// by the ROM reader so the field layout lives in one place.
module game_ui_entry_decode
  import game_ui_pkg::*;
#(
  parameter int ENTRY_WIDTH = 64
) (
  input  logic [ENTRY_WIDTH-1:0] word_i,
  output ui_entry_t              entry_o
);

  assign entry_o.rst       = word_i[UI_RST_BIT];
  assign entry_o.x         = word_i[UI_X_LSB    +: UI_GEOM_W];
  assign entry_o.y         = word_i[UI_Y_LSB    +: UI_GEOM_W];
  assign entry_o.w         = word_i[UI_W_LSB    +: UI_GEOM_W];
  assign entry_o.h         = word_i[UI_H_LSB    +: UI_GEOM_W];
  assign entry_o.sens      = word_i[UI_SENS_LSB +: UI_SENS_W];
  assign entry_o.wait_time = word_i[UI_WAIT_LSB +: UI_WAIT_W];

endmodule

// File: rtl/game_ui_sequencer.sv
// UI script sequencer: fetches ROM entries into shadow registers and applies
// them at their scheduled game time. GAME_UI_SEQ_LOOP_EN makes the script loop.
module game_ui_sequencer
  import game_ui_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int ENTRY_WIDTH   = 64
) (
  input  logic                clk_calculation,
  input  logic                reset_n,
  game_ui_sequencer_if.master bus
);

  ui_seq_state_t            state_q;
  logic [ADDR_WIDTH-1:0]    rom_addr_q;
  logic [MAXIMUM_TIMES-1:0] next_time_q;
  ui_entry_t                shadow_q;
  logic [9:0]               pos_x_q, pos_y_q, w_q, h_q;
  logic [6:0]               sens_q;
  logic                     health_reset_q, applied_q;

  ui_entry_t                rom_entry;
  logic                     script_end;
  logic [UI_WAIT_W-1:0]     step_wait;
  logic [MAXIMUM_TIMES-1:0] sched_time;

  game_ui_entry_decode #(.ENTRY_WIDTH(ENTRY_WIDTH)) u_decode (
    .word_i  (bus.rom_data),
    .entry_o (rom_entry)
  );

  // Schedules clamp at the end of the time range instead of wrapping back
  // into the past, which would fire the next entry immediately.
  function automatic logic [MAXIMUM_TIMES-1:0] sat_add(
    input logic [MAXIMUM_TIMES-1:0] t,
    input logic [UI_WAIT_W-1:0]     w
  );
    logic [MAXIMUM_TIMES:0] sum;
    sum = {1'b0, t} + {{(MAXIMUM_TIMES + 1 - UI_WAIT_W){1'b0}}, w};
    return sum[MAXIMUM_TIMES] ? '1 : sum[MAXIMUM_TIMES-1:0];
  endfunction

  assign script_end = is_hold(shadow_q.wait_time) || (&rom_addr_q);
`ifdef GAME_UI_SEQ_LOOP_EN
  assign step_wait  = is_hold(shadow_q.wait_time) ? '0 : shadow_q.wait_time;
`else
  assign step_wait  = shadow_q.wait_time;
`endif
  assign sched_time = sat_add(bus.current_time, step_wait);

  always_ff @(posedge clk_calculation or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      rom_addr_q     <= '0;
      next_time_q    <= '0;
      shadow_q       <= '{rst: 1'b0, x: '0, y: '0, w: '0, h: '0,
                          sens: UI_SENS_RESET, wait_time: '0};
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      w_q            <= '0;
      h_q            <= '0;
      sens_q         <= UI_SENS_RESET;
      health_reset_q <= 1'b0;
      applied_q      <= 1'b0;
    end else begin
      health_reset_q <= 1'b0;
      applied_q      <= 1'b0;
      if (bus.abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              rom_addr_q  <= '0;
              next_time_q <= bus.current_time;
              state_q     <= ST_FETCH;
            end
          end
          ST_FETCH: state_q <= ST_LATCH;
          ST_LATCH: begin
            shadow_q <= rom_entry;
            state_q  <= ST_WAIT;
          end
          // Active outputs and pulses are loaded on the edge entering APPLY,
          // so they are visible for exactly the APPLY cycle.
          ST_WAIT: begin
            if (bus.current_time >= next_time_q) begin
              pos_x_q        <= shadow_q.x;
              pos_y_q        <= shadow_q.y;
              w_q            <= shadow_q.w;
              h_q            <= shadow_q.h;
              sens_q         <= shadow_q.sens;
              health_reset_q <= shadow_q.rst;
              applied_q      <= 1'b1;
              state_q        <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            if (script_end) begin
`ifdef GAME_UI_SEQ_LOOP_EN
              rom_addr_q  <= '0;
              next_time_q <= sched_time;
              state_q     <= ST_FETCH;
`else
              state_q     <= ST_DONE;
`endif
            end else begin
              rom_addr_q  <= rom_addr_q + 1'b1;
              next_time_q <= sched_time;
              state_q     <= ST_FETCH;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr               = rom_addr_q;
  assign bus.next_ui_time           = next_time_q;
  assign bus.health_bar_pos_x       = pos_x_q;
  assign bus.health_bar_pos_y       = pos_y_q;
  assign bus.health_bar_w           = w_q;
  assign bus.health_bar_h           = h_q;
  assign bus.health_bar_sensitivity = sens_q;
  assign bus.health_reset           = health_reset_q;
  assign bus.entry_applied          = applied_q;
  assign bus.running                = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done                   = (state_q == ST_DONE);
  assign bus.dbg_state              = state_q;

endmodule

// File: tb/tb_game_ui_sequencer.sv
// Directed bench for game_ui_sequencer: script apply timing, WAIT stall,
// HOLD end (DONE or loop under GAME_UI_SEQ_LOOP_EN), abort, saturation, reset.
module tb_game_ui_sequencer;
  import game_ui_pkg::*;

  localparam int AW = 10;
  localparam int MT = 30;
  localparam int EW = 64;

  logic clk;
  logic reset_n;
  logic [EW-1:0] rom [1024];

  int n_cmp = 0;
  int n_err = 0;

  game_ui_sequencer_if #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT), .ENTRY_WIDTH(EW)) bus ();

  game_ui_sequencer #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT), .ENTRY_WIDTH(EW)) dut (
    .clk_calculation (clk),
    .reset_n         (reset_n),
    .bus             (bus)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle read latency
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // ---- driver tasks ----
  function automatic logic [63:0] mk(input logic r, input logic [9:0] x, y, w, h,
                                     input logic [6:0] s, input logic [15:0] wt);
    return {r, x, y, w, h, s, wt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = mk(1'b1, 10'd100, 10'd400, 10'd200, 10'd20, 7'd5, 16'd50);
    rom[1] = mk(1'b0, 10'd11, 10'd22, 10'd33, 10'd44, 7'd9, 16'd0);
    rom[2] = mk(1'b1, 10'd7, 10'd8, 10'd9, 10'd10, 7'd3, 16'hFFFF);

    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.current_time = '0;
    step(); step();
    reset_n = 1'b1;
    step();

    // reset state
    check("rst_state", bus.dbg_state, ST_IDLE);
    check("rst_x", bus.health_bar_pos_x, 0);
    check("rst_sens", bus.health_bar_sensitivity, 127);
    check("rst_running", bus.running, 0);
    check("rst_done", bus.done, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_next", bus.next_ui_time, 0);
    check("rst_applied", bus.entry_applied, 0);

    // entry0: apply 4 cycles after start
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("e0_fetch", bus.dbg_state, ST_FETCH);
    check("e0_running", bus.running, 1);
    step();
    step();
    check("e0_wait", bus.dbg_state, ST_WAIT);
    check("e0_no_early", bus.entry_applied, 0);
    step();
    check("e0_applied", bus.entry_applied, 1);
    check("e0_hreset", bus.health_reset, 1);
    check("e0_x", bus.health_bar_pos_x, 100);
    check("e0_y", bus.health_bar_pos_y, 400);
    check("e0_w", bus.health_bar_w, 200);
    check("e0_h", bus.health_bar_h, 20);
    check("e0_sens", bus.health_bar_sensitivity, 5);
    step();
    check("e0_next", bus.next_ui_time, 50);
    check("e0_addr", bus.rom_addr, 1);
    check("e0_pulse_end", bus.entry_applied, 0);

    // entry1 waits for current_time >= 50
    step(); step();
    check("e1_wait", bus.dbg_state, ST_WAIT);
    bus.current_time = 30'd49;
    step(); step();
    check("e1_stall", bus.dbg_state, ST_WAIT);
    check("e1_stall_pulse", bus.entry_applied, 0);
    bus.current_time = 30'd50;
    step();
    check("e1_applied", bus.entry_applied, 1);
    check("e1_hreset", bus.health_reset, 0);
    check("e1_x", bus.health_bar_pos_x, 11);
    check("e1_sens", bus.health_bar_sensitivity, 9);
    step();
    check("e1_next", bus.next_ui_time, 50);
    check("e1_addr", bus.rom_addr, 2);

    // entry2 (HOLD) applies 4 cycles after entry1
    step(); step(); step();
    check("e2_applied", bus.entry_applied, 1);
    check("e2_hreset", bus.health_reset, 1);
    check("e2_x", bus.health_bar_pos_x, 7);
    step();
`ifdef GAME_UI_SEQ_LOOP_EN
    check("end_state", bus.dbg_state, ST_FETCH);
    check("end_addr", bus.rom_addr, 0);
    check("end_next", bus.next_ui_time, 50);
    check("end_done", bus.done, 0);
`else
    check("end_state", bus.dbg_state, ST_DONE);
    check("end_done", bus.done, 1);
    check("end_running", bus.running, 0);
    check("end_x_held", bus.health_bar_pos_x, 7);
`endif
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle", bus.dbg_state, ST_IDLE);

    // abort in WAIT while the apply condition already holds
    bus.current_time = 30'd60;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    check("ab_wait", bus.dbg_state, ST_WAIT);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_idle", bus.dbg_state, ST_IDLE);
    check("ab_no_pulse", bus.entry_applied, 0);
    check("ab_no_hreset", bus.health_reset, 0);
    check("ab_x_held", bus.health_bar_pos_x, 7);
    check("ab_sens_held", bus.health_bar_sensitivity, 3);
    check("ab_running", bus.running, 0);

    // saturating schedule near the top of the time range
    rom[0] = mk(1'b0, 10'd1, 10'd2, 10'd3, 10'd4, 7'd6, 16'd100);
    bus.current_time = 30'h3FFF_FFF6;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    check("sat_applied", bus.entry_applied, 1);
    check("sat_x", bus.health_bar_pos_x, 1);
    step();
    check("sat_next", bus.next_ui_time, 30'h3FFF_FFFF);
    check("sat_addr", bus.rom_addr, 1);

    // asynchronous reset during LATCH
    step();
    check("rl_latch", bus.dbg_state, ST_LATCH);
    reset_n = 1'b0;
    #1;
    check("rl_state", bus.dbg_state, ST_IDLE);
    check("rl_x", bus.health_bar_pos_x, 0);
    check("rl_sens", bus.health_bar_sensitivity, 127);
    check("rl_addr", bus.rom_addr, 0);
    check("rl_next", bus.next_ui_time, 0);
    check("rl_running", bus.running, 0);
    bus.start = 1'b1;
    step(); step();
    check("rl_start_ignored", bus.dbg_state, ST_IDLE);
    bus.start = 1'b0;
    reset_n = 1'b1;
    step();
    check("rl_post_idle", bus.dbg_state, ST_IDLE);
    check("rl_post_running", bus.running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
